// File: rtl/k_and_s_pkg.sv
// k_and_s_pkg -- shared definitions for the K-and-S processor datapath.
//   DATA_W / ADDR_W / NREG  : data width, memory address width, register count
//   decoded_instruction_type: decoded IR opcode as seen by the control unit
//   OPC_*                   : IR[15:8] opcode values
//   ALU_*                   : encodings of the 2-bit ALU operation strobe
package k_and_s_pkg;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned ADDR_W = 5;
   localparam int unsigned NREG   = 4;
   localparam int unsigned REG_AW = $clog2(NREG);

   typedef enum logic [3:0] {
      I_NOP,
      I_BRANCH,
      I_BZERO,
      I_BNZERO,
      I_BNEG,
      I_BNNEG,
      I_BOV,
      I_BNOV,
      I_LOAD,
      I_STORE,
      I_MOVE,
      I_ADD,
      I_SUB,
      I_AND,
      I_OR,
      I_HALT
   } decoded_instruction_type;

   localparam logic [7:0] OPC_NOP    = 8'h00;
   localparam logic [7:0] OPC_BRANCH = 8'h01;
   localparam logic [7:0] OPC_BZERO  = 8'h02;
   localparam logic [7:0] OPC_BNZERO = 8'h0A;
   localparam logic [7:0] OPC_BNEG   = 8'h03;
   localparam logic [7:0] OPC_BNNEG  = 8'h0B;
   localparam logic [7:0] OPC_BOV    = 8'h04;
   localparam logic [7:0] OPC_BNOV   = 8'h0C;
   localparam logic [7:0] OPC_LOAD   = 8'h81;
   localparam logic [7:0] OPC_STORE  = 8'h82;
   localparam logic [7:0] OPC_MOVE   = 8'h91;
   localparam logic [7:0] OPC_ADD    = 8'hA1;
   localparam logic [7:0] OPC_SUB    = 8'hA2;
   localparam logic [7:0] OPC_AND    = 8'hA3;
   localparam logic [7:0] OPC_OR     = 8'hA4;
   localparam logic [7:0] OPC_HALT   = 8'hFF;

   localparam logic [1:0] ALU_OR  = 2'b00;
   localparam logic [1:0] ALU_ADD = 2'b01;
   localparam logic [1:0] ALU_SUB = 2'b10;
   localparam logic [1:0] ALU_AND = 2'b11;

endpackage

// File: rtl/datapath_alu.sv
// alu -- combinational 16-bit ALU of the K-and-S datapath.
//   a, b              : operands (register read ports A and B)
//   operation         : ALU_OR / ALU_ADD / ALU_SUB / ALU_AND
//   result            : operation result
//   zero, neg         : result == 0, result[15]
//   unsigned_overflow : carry-out on ADD, borrow (a < b) on SUB, 0 otherwise
//   signed_overflow   : two's-complement overflow on ADD/SUB, 0 otherwise
module alu
   import k_and_s_pkg::*;
(
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [1:0]        operation,
   output logic [DATA_W-1:0] result,
   output logic              zero,
   output logic              neg,
   output logic              unsigned_overflow,
   output logic              signed_overflow
);

   logic [DATA_W:0]   sum;
   logic [DATA_W-1:0] diff;

   assign sum  = {1'b0, a} + {1'b0, b};
   assign diff = a - b;

   always_comb begin
      result            = '0;
      unsigned_overflow = 1'b0;
      signed_overflow   = 1'b0;
      case (operation)
         ALU_OR:  result = a | b;
         ALU_ADD: begin
            result            = sum[DATA_W-1:0];
            unsigned_overflow = sum[DATA_W];
            signed_overflow   = (a[DATA_W-1] == b[DATA_W-1]) &&
                                (sum[DATA_W-1] != a[DATA_W-1]);
         end
         ALU_SUB: begin
            result            = diff;
            unsigned_overflow = (a < b);
            signed_overflow   = (a[DATA_W-1] != b[DATA_W-1]) &&
                                (diff[DATA_W-1] != a[DATA_W-1]);
         end
         default: result = a & b;
      endcase
   end

   assign zero = (result == '0);
   assign neg  = result[DATA_W-1];

endmodule

// File: rtl/datapath.sv
// datapath -- K-and-S processor datapath: PC, IR, register bank, flags
// register and instruction decoder, driven by control_unit strobes.
//   clk, rst               : clock, synchronous active-high reset
//   branch, pc_enable      : PC <= branch ? IR[4:0] : PC+1 when pc_enable
//   ir_enable              : IR <= data_in
//   write_reg_enable       : reg[c] <= c_sel ? data_in : ALU result
//   addr_sel               : ram_addr = addr_sel ? IR[4:0] : PC
//   operation              : ALU operation
//   flags_reg_enable       : capture ALU flags
//   decoded_instruction    : combinational decode of IR[15:8]
//   zero_op, neg_op,
//   unsigned_overflow,
//   signed_overflow        : registered flags
//   ram_addr, data_out     : memory address, store data (register A)
//   data_in                : memory read data
// Build option: K_AND_S_R0_ZERO_EN makes r0 read as zero and ignore writes.
module datapath
   import k_and_s_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    branch,
   input  logic                    pc_enable,
   input  logic                    ir_enable,
   input  logic                    write_reg_enable,
   input  logic                    addr_sel,
   input  logic                    c_sel,
   input  logic [1:0]              operation,
   input  logic                    flags_reg_enable,
   output decoded_instruction_type decoded_instruction,
   output logic                    zero_op,
   output logic                    neg_op,
   output logic                    unsigned_overflow,
   output logic                    signed_overflow,
   output logic [ADDR_W-1:0]       ram_addr,
   output logic [DATA_W-1:0]       data_out,
   input  logic [DATA_W-1:0]       data_in
);

   logic [ADDR_W-1:0] pc;
   logic [DATA_W-1:0] ir;
   logic [DATA_W-1:0] regs [NREG];
   logic [REG_AW-1:0] a_addr, b_addr, c_addr;
   logic [DATA_W-1:0] a_data, b_data, c_data, alu_result;
   logic              alu_zero, alu_neg, alu_uov, alu_sov;

   // Decode and register-address selection in one pass over the whole IR.
   always_comb begin
      decoded_instruction = I_NOP;
      a_addr = '0;
      b_addr = '0;
      c_addr = '0;
      casez (ir)
         {OPC_NOP,    8'b????????}: decoded_instruction = I_NOP;
         {OPC_BRANCH, 8'b????????}: decoded_instruction = I_BRANCH;
         {OPC_BZERO,  8'b????????}: decoded_instruction = I_BZERO;
         {OPC_BNZERO, 8'b????????}: decoded_instruction = I_BNZERO;
         {OPC_BNEG,   8'b????????}: decoded_instruction = I_BNEG;
         {OPC_BNNEG,  8'b????????}: decoded_instruction = I_BNNEG;
         {OPC_BOV,    8'b????????}: decoded_instruction = I_BOV;
         {OPC_BNOV,   8'b????????}: decoded_instruction = I_BNOV;
         {OPC_HALT,   8'b????????}: decoded_instruction = I_HALT;
         {OPC_LOAD,   8'b????????}: begin
            decoded_instruction = I_LOAD;
            c_addr = ir[6:5];
         end
         {OPC_STORE,  8'b????????}: begin
            decoded_instruction = I_STORE;
            a_addr = ir[6:5];
         end
         {OPC_MOVE,   8'b????????}: begin
            decoded_instruction = I_MOVE;
            a_addr = ir[3:2];
            b_addr = ir[3:2];
            c_addr = ir[1:0];
         end
         {OPC_ADD, 8'b????????}, {OPC_SUB, 8'b????????},
         {OPC_AND, 8'b????????}, {OPC_OR,  8'b????????}: begin
            unique case (ir[15:8])
               OPC_ADD: decoded_instruction = I_ADD;
               OPC_SUB: decoded_instruction = I_SUB;
               OPC_AND: decoded_instruction = I_AND;
               default: decoded_instruction = I_OR;
            endcase
            c_addr = ir[5:4];
            a_addr = ir[3:2];
            b_addr = ir[1:0];
         end
         default: decoded_instruction = I_NOP;
      endcase
   end

   always_comb begin
      a_data = regs[a_addr];
      b_data = regs[b_addr];
`ifdef K_AND_S_R0_ZERO_EN
      if (a_addr == '0) a_data = '0;
      if (b_addr == '0) b_data = '0;
`endif
   end

   alu u_alu (
      .a                 (a_data),
      .b                 (b_data),
      .operation         (operation),
      .result            (alu_result),
      .zero              (alu_zero),
      .neg               (alu_neg),
      .unsigned_overflow (alu_uov),
      .signed_overflow   (alu_sov)
   );

   assign c_data   = c_sel ? data_in : alu_result;
   assign ram_addr = addr_sel ? ir[ADDR_W-1:0] : pc;
   assign data_out = a_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         pc <= '0;
         ir <= '0;
         {zero_op, neg_op, unsigned_overflow, signed_overflow} <= '0;
         for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
      end else begin
         if (pc_enable)
            pc <= branch ? ir[ADDR_W-1:0] : pc + 1'b1;
         if (ir_enable)
            ir <= data_in;
         if (flags_reg_enable)
            {zero_op, neg_op, unsigned_overflow, signed_overflow} <=
               {alu_zero, alu_neg, alu_uov, alu_sov};
         if (write_reg_enable) begin
`ifdef K_AND_S_R0_ZERO_EN
            if (c_addr != '0)
`endif
               regs[c_addr] <= c_data;
         end
      end
   end

endmodule

// File: tb/tb_datapath.sv
// tb_datapath -- directed stimulus with a scoreboard queue; a monitor on the
// falling edge pops and compares every expectation due in that cycle.
module tb_datapath;
   import k_and_s_pkg::*;

   logic clk = 1'b0;
   logic rst, branch, pc_enable, ir_enable, write_reg_enable;
   logic addr_sel, c_sel, flags_reg_enable;
   logic [1:0] operation;
   logic [DATA_W-1:0] data_in, data_out;
   logic [ADDR_W-1:0] ram_addr;
   logic zero_op, neg_op, unsigned_overflow, signed_overflow;
   decoded_instruction_type decoded_instruction;

   datapath dut (
      .clk                 (clk),
      .rst                 (rst),
      .branch              (branch),
      .pc_enable           (pc_enable),
      .ir_enable           (ir_enable),
      .write_reg_enable    (write_reg_enable),
      .addr_sel            (addr_sel),
      .c_sel               (c_sel),
      .operation           (operation),
      .flags_reg_enable    (flags_reg_enable),
      .decoded_instruction (decoded_instruction),
      .zero_op             (zero_op),
      .neg_op              (neg_op),
      .unsigned_overflow   (unsigned_overflow),
      .signed_overflow     (signed_overflow),
      .ram_addr            (ram_addr),
      .data_out            (data_out),
      .data_in             (data_in)
   );

   always #5 clk = ~clk;

   localparam int SIG_ADDR = 0, SIG_DEC = 1, SIG_DOUT = 2, SIG_FLAGS = 3;

   typedef struct {
      int          tag;
      int          id;
      logic [15:0] exp;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   checks = 0;
   int   passed = 0;

   function automatic logic [15:0] actual(input int id);
      case (id)
         SIG_ADDR: return {11'b0, ram_addr};
         SIG_DEC:  return {12'b0, decoded_instruction};
         SIG_DOUT: return data_out;
         default:  return {12'b0, zero_op, neg_op, unsigned_overflow, signed_overflow};
      endcase
   endfunction

   // Monitor: outputs are sampled mid-cycle, away from the rising edge.
   initial begin
      exp_t e;
      logic [15:0] act;
      forever begin
         @(negedge clk);
         cyc++;
         while (sb.size() > 0 && sb[0].tag <= cyc) begin
            e = sb.pop_front();
            act = actual(e.id);
            checks++;
            if (act !== e.exp)
               $display("FAIL %s: got %h expected %h (cycle %0d)", e.name, act, e.exp, cyc);
            else
               passed++;
         end
      end
   end

   task automatic expect_now(input int id, input logic [15:0] exp, input string name);
      sb.push_back('{cyc + 1, id, exp, name});
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic idle();
      rst = 0; branch = 0; pc_enable = 0; ir_enable = 0; write_reg_enable = 0;
      addr_sel = 0; c_sel = 0; operation = ALU_OR; flags_reg_enable = 0;
      data_in = '0;
   endtask

   task automatic load_ir(input logic [15:0] val);
      idle();
      ir_enable = 1; data_in = val;
      step();
      idle();
   endtask

   task automatic alu_write(input logic [1:0] op);
      idle();
      operation = op; flags_reg_enable = 1; write_reg_enable = 1; c_sel = 0;
   endtask

   logic [15:0]             dec_ir  [5] = '{16'hFF00, 16'h5500, 16'h0B00, 16'h9100, 16'h0C00};
   decoded_instruction_type dec_exp [5] = '{I_HALT, I_NOP, I_BNNEG, I_MOVE, I_BNOV};

   initial begin
      idle();
      rst = 1;
      step(); step();
      idle();
      expect_now(SIG_ADDR,  16'h0000, "reset_ram_addr");
      expect_now(SIG_DEC,   16'(I_NOP), "reset_decode");
      expect_now(SIG_FLAGS, 16'h0000, "reset_flags");
      expect_now(SIG_DOUT,  16'h0000, "reset_data_out");

      // Fetch: IR <= mem[PC=0], PC advances on the same edge.
      ir_enable = 1; pc_enable = 1; data_in = 16'h8145;
      expect_now(SIG_ADDR, 16'h0000, "fetch_addr_pc0");
      step();
      idle(); addr_sel = 1;
      expect_now(SIG_DEC,  16'(I_LOAD), "fetch_decode_load");
      expect_now(SIG_ADDR, 16'h0005, "fetch_ram_addr_ir");
      step();
      idle();
      expect_now(SIG_ADDR, 16'h0001, "fetch_pc_advanced");
      step();

      // LOAD r1 <= 0x7FFF
      load_ir(16'h8125);
      c_sel = 1; write_reg_enable = 1; data_in = 16'h7FFF;
      step();
      load_ir(16'h8220);
      expect_now(SIG_DEC,  16'(I_STORE), "store_decode");
      expect_now(SIG_DOUT, 16'h7FFF, "load_r1");
      step();

      // ADD r2 = r1 + r1
      load_ir(16'hA125);
      alu_write(ALU_ADD);
      expect_now(SIG_DEC,  16'(I_ADD), "add_decode");
      expect_now(SIG_DOUT, 16'h7FFF, "add_read_a");
      step();
      idle();
      expect_now(SIG_FLAGS, 16'b0101, "add_flags");
      step();
      load_ir(16'h8240);
      expect_now(SIG_DOUT,  16'hFFFE, "add_r2");
      expect_now(SIG_FLAGS, 16'b0101, "flags_hold");
      step();

      // r1 <= 1, then SUB r0 = r0 - r1
      load_ir(16'h8120);
      c_sel = 1; write_reg_enable = 1; data_in = 16'h0001;
      step();
      load_ir(16'hA201);
      alu_write(ALU_SUB);
      step();
      idle();
      expect_now(SIG_FLAGS, 16'b0110, "sub_borrow_flags");
      step();
      load_ir(16'h8200);
`ifdef K_AND_S_R0_ZERO_EN
      expect_now(SIG_DOUT, 16'h0000, "sub_r0_hardwired");
`else
      expect_now(SIG_DOUT, 16'hFFFF, "sub_r0");
`endif
      step();

      // SUB r0 = r1 - r1 -> zero flag
      load_ir(16'hA205);
      alu_write(ALU_SUB);
      step();
      idle();
      expect_now(SIG_FLAGS, 16'b1000, "sub_zero_flags");
      step();

      // OR r3 = r2 | r1 = 0xFFFF
      load_ir(16'hA439);
      alu_write(ALU_OR);
      expect_now(SIG_DEC, 16'(I_OR), "or_decode");
      step();
      load_ir(16'h8260);
      expect_now(SIG_DOUT,  16'hFFFF, "or_r3");
      expect_now(SIG_FLAGS, 16'b0100, "or_flags");
      step();

      // PC: branch to 31, wrap to 0, branch to 19, branch without enable
      load_ir(16'h021F);
      pc_enable = 1; branch = 1;
      expect_now(SIG_DEC, 16'(I_BZERO), "bzero_decode");
      step();
      idle();
      expect_now(SIG_ADDR, 16'd31, "branch_pc31");
      pc_enable = 1;
      step();
      idle();
      expect_now(SIG_ADDR, 16'd0, "pc_wrap");
      step();
      load_ir(16'h0213);
      pc_enable = 1; branch = 1;
      step();
      idle();
      expect_now(SIG_ADDR, 16'd19, "branch_pc19");
      branch = 1;
      step();
      idle();
      expect_now(SIG_ADDR, 16'd19, "branch_no_enable");
      step();

      // Opcode decode table
      for (int i = 0; i < 5; i++) begin
         load_ir(dec_ir[i]);
         expect_now(SIG_DEC, 16'(dec_exp[i]), "decode_table");
         step();
      end

      // Reset mid-sequence with r3 nonzero and flags set; rst beats strobes
      idle();
      rst = 1; pc_enable = 1; ir_enable = 1; write_reg_enable = 1; c_sel = 1;
      flags_reg_enable = 1; data_in = 16'h8260;
      step();
      idle();
      expect_now(SIG_ADDR,  16'h0000, "rst_ram_addr");
      expect_now(SIG_DEC,   16'(I_NOP), "rst_decode");
      expect_now(SIG_FLAGS, 16'h0000, "rst_flags");
      step();
      load_ir(16'h8260);
      expect_now(SIG_DOUT, 16'h0000, "rst_r3_cleared");
      step();

      for (int i = 0; i < 20 && sb.size() > 0; i++) step();
      if (sb.size() > 0) begin
         checks++;
         $display("FAIL drain: %0d expectations left, required 0", sb.size());
      end
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/datapath.md
# datapath

Datapath of the K-and-S processor, directly downstream of `control_unit`. It holds the PC, IR, 4×16-bit register bank and flags register, and decodes the IR into `decoded_instruction`. It executes the enable/select strobes driven by the control unit each cycle and drives the RAM address and write data. It also returns the registered ALU flags to the control unit for branch decisions.

## Interface
Parameters:
- none; widths come from package constants: DATA_W=16, ADDR_W=5, NREG=4.

Ports:
- `clk`  input  1  system clock, all state on rising edge
- `rst`  input  1  synchronous, active-high reset
- `branch`  input  1  PC load source: 1 = IR[4:0], 0 = PC+1
- `pc_enable`  input  1  PC update strobe
- `ir_enable`  input  1  IR load strobe (IR <= `data_in`)
- `write_reg_enable`  input  1  register bank write strobe
- `addr_sel`  input  1  `ram_addr` source: 1 = IR[4:0], 0 = PC
- `c_sel`  input  1  write-back source: 1 = `data_in`, 0 = ALU result
- `operation`  input  2  ALU op: 00 OR, 01 ADD, 10 SUB, 11 AND
- `flags_reg_enable`  input  1  flags register load strobe
- `decoded_instruction`  output  decoded_instruction_type  combinational decode of IR
- `zero_op`, `neg_op`, `unsigned_overflow`, `signed_overflow`  output  1 each  registered flags
- `ram_addr`  output  5  memory address
- `data_out`  output  16  store data = register A read port
- `data_in`  input  16  memory read data; asynchronous read, valid in the same cycle as `ram_addr`

## Operation
- Reset: PC=0, IR=0x0000, all registers=0, flags=0. `rst` has priority over every strobe. After reset, `decoded_instruction`=I_NOP and `ram_addr`=0.
- Decode (IR[15:8]):
  - 0x00 NOP; 0x01 BRANCH; 0x02 BZERO; 0x0A BNZERO; 0x03 BNEG; 0x0B BNNEG; 0x04 BOV; 0x0C BNOV
  - 0x81 LOAD; 0x82 STORE; 0x91 MOVE; 0xA1 ADD; 0xA2 SUB; 0xA3 AND; 0xA4 OR; 0xFF HALT
  - any other opcode → I_NOP
- Register addresses:
  - LOAD: c = IR[6:5]
  - STORE: a = IR[6:5]
  - MOVE: a = b = IR[3:2], c = IR[1:0]; the control unit drives op=OR, so the result is A
  - ALU ops: c = IR[5:4], a = IR[3:2], b = IR[1:0]
  - All other instructions: a = b = c = 0
- ALU, 16-bit:
  - ADD: `unsigned_overflow` = carry-out; signed overflow when A[15]==B[15] and R[15]!=A[15]
  - SUB: `unsigned_overflow` = borrow (A<B unsigned); signed overflow when A[15]!=B[15] and R[15]!=A[15]
  - OR/AND: both overflow flags = 0
  - zero = (R==0); neg = R[15]
- PC: when `pc_enable`, PC <= `branch` ? IR[4:0] : PC+1, wrapping 31→0. When `branch` is set without `pc_enable`, PC is unchanged.
- Register write: when `write_reg_enable`, reg[c] <= `c_sel` ? `data_in` : ALU result. Reads are combinational; the new value is visible the cycle after the write. Reading and writing the same register in one cycle returns the old value.
- `ir_enable` together with `pc_enable` (fetch): IR captures mem[old PC], and PC advances in the same edge.

## Timing
- `decoded_instruction` is valid in the cycle after the `ir_enable` edge.
- Flags update on the edge where `flags_reg_enable`=1 and are visible to the control unit on the next cycle. They hold otherwise.
- Path from `ram_addr` through `data_in` to the IR/register inputs is single-cycle combinational.
- Sequence lengths: LOAD completes in 4 cycles (fetch, decode, LOAD_1, LOAD_2); an ALU op completes in 3.
- Reset mid-instruction: state clears on that edge. The next cycle fetches from address 0.

## Configuration
- `K_AND_S_R0_ZERO_EN` defined: register 0 is hard-wired to 0x0000. Writes to r0 are discarded, and reads of r0 always return 0.
- Undefined: r0 is an ordinary register.

## Structure
- `k_and_s_pkg` holds: `decoded_instruction_type` enum, opcode localparams, DATA_W/ADDR_W/NREG, and the ALU operation encodings.
- One sub-module, `alu`, is combinational: A, B and operation in; result and four raw flags out. The PC, IR, register bank, flags register and decoder stay in `datapath`.

## Test plan
- Reset, then drive `ir_enable`+`pc_enable` with `data_in`=0x8145 → IR=0x8145, PC=1, decode I_LOAD. With `addr_sel`=1, `ram_addr`=5.
- LOAD: `c_sel`=1, `write_reg_enable`=1, `data_in`=0x7FFF, IR=0x8125 → r1=0x7FFF.
- ADD r2=r1+r1, IR=0xA125, op=01, `flags_reg_enable`=1, `c_sel`=0, write enabled → r2=0xFFFE. Flags next cycle: neg=1, zero=0, signed_ov=1, unsigned_ov=0.
- SUB with r0=0, r1=1 (IR=0xA201), op=10 → r0=0xFFFF with unsigned_ov=1. Under `K_AND_S_R0_ZERO_EN`, r0 reads back 0 instead.
- PC wrap and branch:
  - PC=31 with `pc_enable` → PC=0
  - IR=0x0213 with `pc_enable`+`branch` → PC=19
  - `branch` alone → PC unchanged
- Assert `rst` mid-sequence with r3 nonzero and flags set → everything is zero the next cycle, and `ram_addr`=0.
